// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and defaults for the push-button debouncer.
// Rev 1.0
`default_nettype none

package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // 10 ms at 100 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw button inputs plus debounced pulse/level outputs.
// Rev 1.0
`default_nettype none

interface button_debouncer_if;
  logic leftBtn;
  logic rightBtn;
  logic leftBtnDebounce;
  logic rightBtnDebounce;
  logic leftHeld;
  logic rightHeld;

  modport master (
    output leftBtn,
    output rightBtn,
    input  leftBtnDebounce,
    input  rightBtnDebounce,
    input  leftHeld,
    input  rightHeld
  );

  modport slave (
    input  leftBtn,
    input  rightBtn,
    output leftBtnDebounce,
    output rightBtnDebounce,
    output leftHeld,
    output rightHeld
  );
endinterface

`default_nettype wire

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchroniser, stability counter and press/release FSM for one button.
// Rev 1.0
`default_nettype none

module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_raw,
  output logic      o_fire,
  output logic      o_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic [1:0] S_IDLE         = IDLE;
  localparam logic [1:0] S_PRESS_WAIT   = PRESS_WAIT;
  localparam logic [1:0] S_PRESSED      = PRESSED;
  localparam logic [1:0] S_RELEASE_WAIT = RELEASE_WAIT;

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_held;
  logic             w_term;

  assign w_term = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_held  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      case (r_state)
        S_IDLE: begin
          if (r_sync2) begin
            r_state <= S_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!r_sync2) begin
            r_state <= S_IDLE;
          end else if (w_term) begin
            r_state <= S_PRESSED;
            r_held  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PRESSED: begin
          if (!r_sync2) begin
            r_state <= S_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        S_RELEASE_WAIT: begin
          // A bounce back high returns to PRESSED silently; only a full press fires.
          if (r_sync2) begin
            r_state <= S_PRESSED;
          end else if (w_term) begin
            r_state <= S_IDLE;
            r_held  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_fire = (r_state == S_PRESS_WAIT) && r_sync2 && w_term;
  assign o_held = r_held;

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
// button_debouncer: two debounce channels with left-priority pulse arbitration.
// Rev 1.0
`default_nettype none

module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  wire logic          clk,
  input  wire logic          reset,
  button_debouncer_if.slave  bus
);

  logic w_left_fire;
  logic w_right_fire;
  logic w_left_held;
  logic w_right_held;
  logic r_left_pulse;
  logic r_right_pulse;
  logic r_right_pending;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk    (clk),
    .rst_n  (reset),
    .i_raw  (bus.leftBtn),
    .o_fire (w_left_fire),
    .o_held (w_left_held)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk    (clk),
    .rst_n  (reset),
    .i_raw  (bus.rightBtn),
    .o_fire (w_right_fire),
    .o_held (w_right_held)
  );

  // Left wins a same-edge collision; right is deferred one cycle so no press is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_left_pulse    <= 1'b0;
      r_right_pulse   <= 1'b0;
      r_right_pending <= 1'b0;
    end else begin
      r_left_pulse    <= w_left_fire;
      r_right_pulse   <= r_right_pending | (w_right_fire & ~w_left_fire);
      r_right_pending <= w_right_fire & w_left_fire;
    end
  end

  assign bus.leftBtnDebounce  = r_left_pulse;
  assign bus.rightBtnDebounce = r_right_pulse;
  assign bus.leftHeld         = w_left_held;
  assign bus.rightHeld        = w_right_held;

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed tables, corner sequences and random stimulus vs a run-length model.
// Rev 1.0
`default_nettype none

module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  button_debouncer_if bus ();

  button_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: debounced level flips once the synchronised input has disagreed with it
  // for N+1 consecutive samples; a collision defers the right pulse by one cycle.
  bit m_sy1 [2];
  bit m_sy2 [2];
  bit m_lvl [2];
  int m_run [2];
  bit m_pend, m_ldb, m_rdb;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_sy1[c] = 0; m_sy2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
    end
    m_pend = 0; m_ldb = 0; m_rdb = 0;
  endfunction

  function automatic void model_edge(input bit l, input bit r);
    bit fire [2];
    bit raw  [2];
    raw[0] = l;
    raw[1] = r;
    for (int c = 0; c < 2; c++) begin
      fire[c] = 0;
      if (m_sy2[c] != m_lvl[c]) m_run[c]++;
      else                      m_run[c] = 0;
      if (m_run[c] == N + 1) begin
        m_lvl[c] = m_sy2[c];
        m_run[c] = 0;
        fire[c]  = m_lvl[c];
      end
      m_sy2[c] = m_sy1[c];
      m_sy1[c] = raw[c];
    end
    m_ldb  = fire[0];
    m_rdb  = m_pend | (fire[1] & !fire[0]);
    m_pend = fire[1] & fire[0];
  endfunction

  function automatic int dut_out();
    return int'({bus.leftBtnDebounce, bus.rightBtnDebounce, bus.leftHeld, bus.rightHeld});
  endfunction

  function automatic int model_out();
    return int'({m_ldb, m_rdb, m_lvl[0], m_lvl[1]});
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input bit l, input bit r);
    bus.leftBtn  = l;
    bus.rightBtn = r;
    @(posedge clk);
    model_edge(l, r);
    @(negedge clk);
    check("model", dut_out(), model_out());
  endtask

  task automatic hold_reset(input int cyc);
    reset = 1'b0;
    model_reset();
    repeat (cyc) @(negedge clk);
    check("reset_zero", dut_out(), 0);
    reset = 1'b1;
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) step(0, 0);
  endtask

  typedef struct {
    bit       l;
    bit       r;
    logic [3:0] exp;  // {leftBtnDebounce, rightBtnDebounce, leftHeld, rightHeld}
  } vec_t;

  vec_t tbl [10];

  initial begin
    int pulses, at, seen;
    bit l, r;

    bus.leftBtn  = 0;
    bus.rightBtn = 0;
    model_reset();

    for (int k = 0; k < 10; k++) begin
      tbl[k].l = 1;
      tbl[k].r = 1;
      tbl[k].exp = (k < 6) ? 4'b0000 : (k == 6) ? 4'b1011 : (k == 7) ? 4'b0111 : 4'b0011;
    end

    @(negedge clk);

    // Reset held with both buttons pressed; then treated as a fresh press.
    bus.leftBtn  = 1;
    bus.rightBtn = 1;
    hold_reset(5);
    for (int k = 0; k < 10; k++) begin
      step(1, 1);
      if (k == 5) check("t1_pre_pulse", dut_out(), 4'b0000);
      if (k == 6) check("t1_left_pulse", dut_out(), 4'b1011);
      if (k == 7) check("t1_right_pulse", dut_out(), 4'b0111);
    end
    idle(10);

    // Simultaneous rise, table driven.
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].l, tbl[k].r);
      check("t4_table", dut_out(), int'(tbl[k].exp));
    end
    idle(10);

    // Bounce before a stable press.
    pulses = 0; at = -1;
    for (int k = 0; k < 18; k++) begin
      l = (k >= 8) ? 1'b1 : ((k % 4) < 2);
      step(l, 0);
      if (bus.leftBtnDebounce) begin pulses++; at = k; end
    end
    check("t2_pulse_count", pulses, 1);
    check("t2_pulse_edge", at, 14);
    idle(10);

    // Long hold, bouncy release.
    pulses = 0; at = -1;
    for (int k = 0; k < 65; k++) begin
      l = (k < 50) || (k == 51) || (k == 52);
      step(l, 0);
      if (bus.leftBtnDebounce || bus.rightBtnDebounce) pulses++;
      if (k == 58) check("t3_held_before", int'(bus.leftHeld), 1);
      if (k == 59) check("t3_held_drop", int'(bus.leftHeld), 0);
    end
    check("t3_pulse_count", pulses, 1);

    // Reset asserted mid PRESS_WAIT while right is already held.
    for (int k = 0; k < 10; k++) step(0, 1);
    for (int k = 0; k < 5; k++) step(1, 1);
    #2 reset = 1'b0;
    model_reset();
    #1 check("t5_async_zero", dut_out(), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    at = -1;
    for (int k = 0; k < 10; k++) begin
      step(1, 1);
      if (bus.leftBtnDebounce && at < 0) at = k;
    end
    check("t5_pulse_edge", at, 6);
    idle(10);

    // Short glitch on right.
    seen = 0;
    for (int k = 0; k < 13; k++) begin
      step(0, k < 3);
      if (bus.rightBtnDebounce || bus.rightHeld) seen++;
    end
    check("t6_no_activity", seen, 0);

    // Random slowly-toggling buttons against the model.
    l = 0; r = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) l = ~l;
      if ($urandom_range(0, 7) == 0) r = ~r;
      step(l, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
